// File: rtl/tone_synth_if.sv
// Sample stream between tone_synth (master) and the audio codec serializer (slave).
// A sample transfers on every clock edge where sampleValid && sampleReady; sampleData is held while sampleValid is high.
interface tone_synth_if;
    logic [15:0] sampleData;
    logic        sampleValid;
    logic        sampleReady;

    modport master (
        output sampleData,
        output sampleValid,
        input  sampleReady
    );

    modport slave (
        input  sampleData,
        input  sampleValid,
        output sampleReady
    );
endinterface

// File: rtl/tone_synth.sv
// Tone synthesizer: preScaleValue-driven 256-step phase wheel with an attack/sustain/release envelope.
// Define TONE_TRIANGLE_EN to replace the square waveform with a triangle.
module tone_synth #(
    parameter logic [15:0] AMPLITUDE = 16'h2000,
    parameter int          GAIN_MAX  = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic [9:0] preScaleValue,
    tone_synth_if.master snd,
    output logic       sampleOverrun,
    output logic       envBusy,
    output logic [1:0] envState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } envState_t;

    localparam logic [4:0] GAIN_FULL = 5'(GAIN_MAX);

    envState_t   state;
    envState_t   nextState;
    logic [4:0]  gain;
    logic [4:0]  nextGain;
    logic [9:0]  activePrescale;
    logic [9:0]  divCnt;
    logic [7:0]  phase;
    logic [7:0]  phaseNext;
    logic        prescaleChange;
    logic        divRun;
    logic        idleEntry;
    logic        tick;
    logic [15:0] ampScaled;
    logic [15:0] waveSample;
    logic [15:0] sampleDataReg;
    logic        sampleValidReg;

    // Envelope: transition first, then the gain step follows the new state's direction.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (preScaleValue != '0) nextState = ATTACK;
            ATTACK:  begin
                if (preScaleValue == '0)     nextState = RELEASE;
                else if (gain == GAIN_FULL)  nextState = SUSTAIN;
            end
            SUSTAIN: if (preScaleValue == '0) nextState = RELEASE;
            RELEASE: begin
                if (preScaleValue != '0)               nextState = ATTACK;
                else if (gain == '0 && startOfFrame)   nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        nextGain = gain;
        case (nextState)
            IDLE:    nextGain = '0;
            ATTACK:  if (startOfFrame && gain < GAIN_FULL) nextGain = gain + 5'd1;
            SUSTAIN: nextGain = GAIN_FULL;
            RELEASE: if (startOfFrame && gain != '0)       nextGain = gain - 5'd1;
            default: nextGain = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
            gain  <= '0;
        end else begin
            state <= nextState;
            gain  <= nextGain;
        end
    end

    assign envBusy  = (state != IDLE);
    assign envState = state;

    // A pitch change restarts the divider without a tick so the phase wheel stays continuous.
    assign prescaleChange = (preScaleValue != '0) && (preScaleValue != activePrescale);
    assign divRun         = (state != IDLE);
    assign idleEntry      = (state != IDLE) && (nextState == IDLE);
    assign tick           = divRun && !prescaleChange && (activePrescale != '0) &&
                            (divCnt == activePrescale - 10'd1);
    assign phaseNext      = phase + 8'd1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            activePrescale <= '0;
        end else if (preScaleValue != '0) begin
            activePrescale <= preScaleValue;
        end
    end

    // Clearing the divider on IDLE entry gives every new note a full first period.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            divCnt <= '0;
        end else if (prescaleChange || idleEntry || tick) begin
            divCnt <= '0;
        end else if (divRun) begin
            divCnt <= divCnt + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase <= '0;
        end else if (idleEntry) begin
            phase <= '0;
        end else if (tick) begin
            phase <= phaseNext;
        end
    end

    assign ampScaled = 16'(({5'd0, AMPLITUDE} * {16'd0, gain}) >> 4);

`ifdef TONE_TRIANGLE_EN
    logic [15:0] triRamp;
    assign triRamp    = 16'((24'(phaseNext[6:0]) * 24'({ampScaled, 1'b0})) >> 7);
    assign waveSample = phaseNext[7] ? (ampScaled - triRamp) : (triRamp - ampScaled);
`else
    assign waveSample = phaseNext[7] ? (16'd0 - ampScaled) : ampScaled;
`endif

    // A tick always lands new data; overwriting an unconsumed sample is latched as overrun.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sampleDataReg  <= '0;
            sampleValidReg <= 1'b0;
            sampleOverrun  <= 1'b0;
        end else if (tick) begin
            sampleDataReg  <= waveSample;
            sampleValidReg <= 1'b1;
            if (sampleValidReg && !snd.sampleReady) sampleOverrun <= 1'b1;
        end else if (sampleValidReg && snd.sampleReady) begin
            sampleValidReg <= 1'b0;
        end
    end

    assign snd.sampleData  = sampleDataReg;
    assign snd.sampleValid = sampleValidReg;

endmodule
